// File: rtl/dump_sustain_sequencer_pkg.sv
// Shared constants for the dump/sustain echo-train sequencer: default widths
// and the one-hot state encoding. Outputs decode directly from these bits.
`timescale 1ns/1ps
package dump_sustain_sequencer_pkg;

  localparam int DSS_CNT_W = 4;
  localparam int DSS_REP_W = 8;

  // Bit positions of the one-hot state register
  localparam int ST_IDLE = 0;
  localparam int ST_ARM  = 1;
  localparam int ST_DUMP = 2;
  localparam int ST_SUST = 3;
  localparam int ST_DONE = 4;
  localparam int ST_NUM  = 5;

  typedef enum logic [ST_NUM-1:0] {
    S_IDLE = 5'b00001,
    S_ARM  = 5'b00010,
    S_DUMP = 5'b00100,
    S_SUST = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

endpackage

// File: rtl/dump_sustain_sequencer_tick_sync_edge.sv
// Brings a slow asynchronous timebase into clk_sys through a flop chain and
// turns each rising edge into a single-cycle tick. SYNC_STAGES must be >= 2.
`timescale 1ns/1ps
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Synchronizer shift chain plus the one-cycle-delayed copy used for edge detection
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign tick = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/dump_sustain_sequencer.sv
// Dump/sustain phase sequencer for one NMR echo train. A train is ARM (wait for
// the timebase), then rep_num pairs of DUMP (dump_len ticks) and SUST
// (sustain_len ticks), then a one-cycle DONE. Phase changes only happen on
// tick cycles, so every phase edge is aligned to the 10 kHz timebase.
`timescale 1ns/1ps
module dump_sustain_sequencer
  import dump_sustain_sequencer_pkg::*;
#(
  parameter int CNT_W       = DSS_CNT_W,
  parameter int REP_W       = DSS_REP_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             clk_10k,
  input  logic             start_req,
  input  logic             abort,
  input  logic [CNT_W-1:0] dump_len,
  input  logic [CNT_W-1:0] sustain_len,
  input  logic [REP_W-1:0] rep_num,
  output logic             dump_en,
  output logic             sustain_en,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
);

  logic tick;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [CNT_W-1:0] dump_len_reg, dump_len_next;
  logic [CNT_W-1:0] sustain_len_reg, sustain_len_next;
  logic [REP_W-1:0] rep_num_reg, rep_num_next;

  logic   dump_last, sust_last, pair_last;
  state_t first_phase;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .async_in (clk_10k),
    .tick     (tick)
  );

  // Counters clear on match, so len-1 never wraps; len==0 phases are skipped
  // before they are entered and never reach these compares.
  assign dump_last   = (cnt_reg == dump_len_reg - CNT_W'(1));
  assign sust_last   = (cnt_reg == sustain_len_reg - CNT_W'(1));
  assign pair_last   = (rep_cnt_reg == rep_num_reg - REP_W'(1));
  assign first_phase = (dump_len_reg != '0) ? S_DUMP : S_SUST;

  // State, phase counter, pair index and captured train configuration
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      rep_cnt_reg     <= '0;
      dump_len_reg    <= '0;
      sustain_len_reg <= '0;
      rep_num_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      rep_cnt_reg     <= rep_cnt_next;
      dump_len_reg    <= dump_len_next;
      sustain_len_reg <= sustain_len_next;
      rep_num_reg     <= rep_num_next;
    end
  end

  // Next-state logic; abort outside IDLE overrides everything else
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    rep_cnt_next     = rep_cnt_reg;
    dump_len_next    = dump_len_reg;
    sustain_len_next = sustain_len_reg;
    rep_num_next     = rep_num_reg;

    if (abort && !state_reg[ST_IDLE]) begin
      state_next   = S_IDLE;
      cnt_next     = '0;
      rep_cnt_next = '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start_req && !abort) begin
            dump_len_next    = dump_len;
            sustain_len_next = sustain_len;
            rep_num_next     = rep_num;
            cnt_next         = '0;
            rep_cnt_next     = '0;
            if (rep_num == '0 || (dump_len == '0 && sustain_len == '0)) begin
              state_next = S_DONE;
            end else begin
              state_next = S_ARM;
            end
          end
        end
        S_ARM: begin
          if (tick) begin
            cnt_next   = '0;
            state_next = first_phase;
          end
        end
        S_DUMP: begin
          if (tick) begin
            if (dump_last) begin
              cnt_next = '0;
              if (sustain_len_reg != '0) begin
                state_next = S_SUST;
              end else if (pair_last) begin
                state_next = S_DONE;
              end else begin
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
                state_next   = first_phase;
              end
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        S_SUST: begin
          if (tick) begin
            if (sust_last) begin
              cnt_next = '0;
              if (pair_last) begin
                state_next = S_DONE;
              end else begin
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
                state_next   = first_phase;
              end
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next   = S_IDLE;
          cnt_next     = '0;
          rep_cnt_next = '0;
        end
      endcase
    end
  end

  assign dump_en    = state_reg[ST_DUMP];
  assign sustain_en = state_reg[ST_SUST];
  assign busy       = ~state_reg[ST_IDLE];
  assign done       = state_reg[ST_DONE];
  assign rep_cnt    = rep_cnt_reg;

endmodule

// File: tb/tb_dump_sustain_sequencer.sv
// Directed bench for dump_sustain_sequencer. clk_sys is 20 MHz; clk_10k is
// scaled down to a 40-cycle period so the run stays short. clk_10k toggles on
// clk_sys falling edges, so a rise seen at negedge t reaches the FSM on the
// third following rising edge: state is unchanged at t+2 negedges and updated
// at t+3 negedges.
`timescale 1ns/1ps
module tb_dump_sustain_sequencer;

  localparam int CNT_W       = 4;
  localparam int REP_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 20;

  logic             clk_sys = 1'b0;
  logic             rst;
  logic             clk_10k;
  logic             start_req;
  logic             abort;
  logic [CNT_W-1:0] dump_len;
  logic [CNT_W-1:0] sustain_len;
  logic [REP_W-1:0] rep_num;
  logic             dump_en;
  logic             sustain_en;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] rep_cnt;

  int total = 0;
  int bad   = 0;

  dump_sustain_sequencer #(
    .CNT_W       (CNT_W),
    .REP_W       (REP_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .clk_10k     (clk_10k),
    .start_req   (start_req),
    .abort       (abort),
    .dump_len    (dump_len),
    .sustain_len (sustain_len),
    .rep_num     (rep_num),
    .dump_en     (dump_en),
    .sustain_en  (sustain_en),
    .busy        (busy),
    .done        (done),
    .rep_cnt     (rep_cnt)
  );

  always #25 clk_sys = ~clk_sys;

  initial begin
    clk_10k = 1'b0;
    forever begin
      repeat (HALF) @(negedge clk_sys);
      clk_10k = ~clk_10k;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit d, input bit s, input bit b,
                         input bit dn, input int rc);
    check({tag, ".dump_en"}, 32'(dump_en), 32'(d));
    check({tag, ".sustain_en"}, 32'(sustain_en), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".rep_cnt"}, 32'(rep_cnt), 32'(rc));
  endtask

  // Issue start_req mid-way through the low half of clk_10k so no tick is in flight
  task automatic start_train(input int d, input int s, input int r);
    @(negedge clk_10k);
    dump_len    = CNT_W'(d);
    sustain_len = CNT_W'(s);
    rep_num     = REP_W'(r);
    start_req   = 1'b1;
    @(negedge clk_sys);
    start_req   = 1'b0;
    $display("train start: dump_len=%0d sustain_len=%0d rep_num=%0d", d, s, r);
  endtask

  // Check phase outputs just before and just after the next tick takes effect
  task automatic tick_step(input string tag, input bit pd, input bit ps, input bit d,
                           input bit s, input bit b, input bit dn, input int rc);
    @(posedge clk_10k);
    repeat (2) @(negedge clk_sys);
    check({tag, ".pre_dump"}, 32'(dump_en), 32'(pd));
    check({tag, ".pre_sust"}, 32'(sustain_en), 32'(ps));
    @(negedge clk_sys);
    chk_all(tag, d, s, b, dn, rc);
  endtask

  initial begin
    bit seen;
    rst         = 1'b1;
    start_req   = 1'b0;
    abort       = 1'b0;
    dump_len    = '0;
    sustain_len = '0;
    rep_num     = '0;

    // Reset values, during and after reset
    repeat (3) @(negedge clk_sys);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk_all("post_reset", 0, 0, 0, 0, 0);

    // 3 DUMP ticks, 2 SUST ticks, one pair
    start_train(3, 2, 1);
    chk_all("t1_arm", 0, 0, 1, 0, 0);
    tick_step("t1_k0", 0, 0, 1, 0, 1, 0, 0);
    tick_step("t1_k1", 1, 0, 1, 0, 1, 0, 0);
    tick_step("t1_k2", 1, 0, 1, 0, 1, 0, 0);
    tick_step("t1_k3", 1, 0, 0, 1, 1, 0, 0);
    tick_step("t1_k4", 0, 1, 0, 1, 1, 0, 0);
    tick_step("t1_k5", 0, 1, 0, 0, 1, 1, 0);
    @(negedge clk_sys);
    chk_all("t1_idle", 0, 0, 0, 0, 0);

    // 1/1 ticks, four pairs: alternating phases, rep_cnt 0..3
    start_train(1, 1, 4);
    chk_all("t2_arm", 0, 0, 1, 0, 0);
    tick_step("t2_k0", 0, 0, 1, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) begin
      tick_step($sformatf("t2_k%0d", i), (i % 2) == 1, (i % 2) == 0,
                (i % 2) == 0, (i % 2) == 1, 1, 0, i / 2);
    end
    tick_step("t2_k8", 0, 1, 0, 0, 1, 1, 3);
    @(negedge clk_sys);
    chk_all("t2_idle", 0, 0, 0, 0, 3);

    // No DUMP phase: SUST held for 10 ticks over two pairs
    start_train(0, 5, 2);
    chk_all("t3_arm", 0, 0, 1, 0, 0);
    tick_step("t3_k0", 0, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i < 10; i++) begin
      tick_step($sformatf("t3_k%0d", i), 0, 1, 0, 1, 1, 0, (i >= 5) ? 1 : 0);
    end
    tick_step("t3_k10", 0, 1, 0, 0, 1, 1, 1);
    @(negedge clk_sys);
    chk_all("t3_idle", 0, 0, 0, 0, 1);

    // rep_num==0 and both lengths zero: straight to DONE, no phases
    @(negedge clk_10k);
    dump_len = 4'd3; sustain_len = 4'd3; rep_num = 8'd0; start_req = 1'b1;
    $display("train start: dump_len=3 sustain_len=3 rep_num=0");
    @(negedge clk_sys);
    start_req = 1'b0;
    chk_all("t3_rep0_done", 0, 0, 1, 1, 0);
    @(negedge clk_sys);
    chk_all("t3_rep0_idle", 0, 0, 0, 0, 0);
    dump_len = 4'd0; sustain_len = 4'd0; rep_num = 8'd5; start_req = 1'b1;
    $display("train start: dump_len=0 sustain_len=0 rep_num=5");
    @(negedge clk_sys);
    start_req = 1'b0;
    chk_all("t3_len0_done", 0, 0, 1, 1, 0);
    @(negedge clk_sys);
    chk_all("t3_len0_idle", 0, 0, 0, 0, 0);

    // Abort during the second DUMP tick
    start_train(4, 1, 2);
    tick_step("t4_k0", 0, 0, 1, 0, 1, 0, 0);
    tick_step("t4_k1", 1, 0, 1, 0, 1, 0, 0);
    repeat (5) @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    chk_all("t4_abort", 0, 0, 0, 0, 0);
    // start_req together with abort is ignored
    start_req = 1'b1;
    @(negedge clk_sys);
    start_req = 1'b0;
    abort = 1'b0;
    check("t4_start_with_abort.busy", 32'(busy), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (done || busy) seen = 1'b1;
    end
    check("t4_quiet_after_abort", 32'(seen), 32'(0));

    // New train accepted; abort in the second pair clears rep_cnt
    start_train(1, 1, 2);
    chk_all("t4b_arm", 0, 0, 1, 0, 0);
    tick_step("t4b_k0", 0, 0, 1, 0, 1, 0, 0);
    tick_step("t4b_k1", 1, 0, 0, 1, 1, 0, 0);
    tick_step("t4b_k2", 0, 1, 1, 0, 1, 0, 1);
    abort = 1'b1;
    @(negedge clk_sys);
    chk_all("t4b_abort", 0, 0, 0, 0, 0);
    abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (done) seen = 1'b1;
    end
    check("t4b_no_done", 32'(seen), 32'(0));

    // start_req while busy and config changed mid-train: captured values rule
    start_train(2, 1, 1);
    tick_step("t5_k0", 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk_sys);
    start_req = 1'b1; dump_len = 4'd7; sustain_len = 4'd5; rep_num = 8'd9;
    @(negedge clk_sys);
    start_req = 1'b0;
    chk_all("t5_ignored", 1, 0, 1, 0, 0);
    tick_step("t5_k1", 1, 0, 1, 0, 1, 0, 0);
    tick_step("t5_k2", 1, 0, 0, 1, 1, 0, 0);
    tick_step("t5_k3", 0, 1, 0, 0, 1, 1, 0);
    @(negedge clk_sys);
    chk_all("t5_idle", 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of SUST
    start_train(1, 3, 1);
    tick_step("t6_k0", 0, 0, 1, 0, 1, 0, 0);
    tick_step("t6_k1", 1, 0, 0, 1, 1, 0, 0);
    @(negedge clk_sys);
    #10;
    rst = 1'b1;
    #1;
    chk_all("t6_async_rst", 0, 0, 0, 0, 0);
    @(negedge clk_sys);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (busy || dump_en || sustain_en || done) seen = 1'b1;
    end
    check("t6_idle_after_rst", 32'(seen), 32'(0));
    start_train(1, 1, 1);
    chk_all("t6_arm", 0, 0, 1, 0, 0);
    tick_step("t6_k2", 0, 0, 1, 0, 1, 0, 0);
    tick_step("t6_k3", 1, 0, 0, 1, 1, 0, 0);
    tick_step("t6_k4", 0, 1, 0, 0, 1, 1, 0);
    @(negedge clk_sys);
    chk_all("t6_idle", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
